// File: rtl/mul_accumulator_if.sv
`default_nettype none
// ============================================================================
// mul_accumulator_if : operand tag handshake, product input and result bus
// Revision 1.0
// ============================================================================
interface mul_accumulator_if #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 16
);
    logic             op_valid;
    logic             op_last;
    logic             op_ready;
    logic [63:0]      p;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] sum_count;
    logic             sum_overflow;
    logic             sum_valid;
    logic             sum_ready;

    modport master (
        output op_valid, op_last, p, sum_ready,
        input  op_ready, sum, sum_count, sum_overflow, sum_valid
    );

    modport slave (
        input  op_valid, op_last, p, sum_ready,
        output op_ready, sum, sum_count, sum_overflow, sum_valid
    );
endinterface
`default_nettype wire

// File: rtl/mul_accumulator.sv
`default_nettype none
// ============================================================================
// mul_accumulator : tags operands into a fixed-latency multiplier and sums
//                   each tagged burst of products into a valid/ready result.
// Revision 1.0
// ============================================================================
module mul_accumulator #(
    parameter int MUL_LATENCY = 6,
    parameter int ACC_W       = 72,
    parameter int CNT_W       = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    mul_accumulator_if.slave  bus
);
    localparam logic [1:0] S_ACCUM = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    logic [1:0]             r_state;
    logic [MUL_LATENCY-1:0] r_tag_v;
    logic [MUL_LATENCY-1:0] r_tag_l;
    logic [ACC_W-1:0]       r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf;
    logic [ACC_W-1:0]       r_sum;
    logic [CNT_W-1:0]       r_sum_count;
    logic                   r_sum_ovf;
    logic                   r_sum_valid;

    logic                   w_op_ready;
    logic                   w_accept;
    logic                   w_out_v;
    logic                   w_out_l;
    logic                   w_out_free;
    logic [ACC_W:0]         w_ext;
    logic [ACC_W-1:0]       w_acc_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_ovf_next;

    assign w_op_ready = (r_state == S_ACCUM);
    assign w_accept   = bus.op_valid && w_op_ready;
    assign w_out_v    = r_tag_v[MUL_LATENCY-1];
    assign w_out_l    = r_tag_l[MUL_LATENCY-1];
    assign w_out_free = !r_sum_valid || bus.sum_ready;

    // Extra top bit captures the carry out of the accumulator width.
    assign w_ext      = {1'b0, r_acc} + {{(ACC_W + 1 - 64){1'b0}}, bus.p};
    assign w_acc_next = w_ext[ACC_W-1:0];
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_ovf_next = r_ovf | w_ext[ACC_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_ACCUM;
            r_tag_v     <= '0;
            r_tag_l     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_sum       <= '0;
            r_sum_count <= '0;
            r_sum_ovf   <= 1'b0;
            r_sum_valid <= 1'b0;
        end else begin
            r_tag_v[0] <= w_accept;
            r_tag_l[0] <= w_accept && bus.op_last;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag_l[i] <= r_tag_l[i-1];
            end

            if (r_sum_valid && bus.sum_ready) begin
                r_sum_valid <= 1'b0;
            end

            case (r_state)
                S_ACCUM: begin
                    if (w_out_v) begin
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        r_ovf <= w_ovf_next;
                    end
                    if (w_accept && bus.op_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_out_v && w_out_l && w_out_free) begin
                        r_sum       <= w_acc_next;
                        r_sum_count <= w_cnt_next;
                        r_sum_ovf   <= w_ovf_next;
                        r_sum_valid <= 1'b1;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= S_ACCUM;
                    end else if (w_out_v) begin
                        // Final value parks in the accumulator until the output frees.
                        r_acc <= w_acc_next;
                        r_cnt <= w_cnt_next;
                        r_ovf <= w_ovf_next;
                        if (w_out_l) begin
                            r_state <= S_EMIT;
                        end
                    end
                end
                S_EMIT: begin
                    if (w_out_free) begin
                        r_sum       <= r_acc;
                        r_sum_count <= r_cnt;
                        r_sum_ovf   <= r_ovf;
                        r_sum_valid <= 1'b1;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= S_ACCUM;
                    end
                end
                default: r_state <= S_ACCUM;
            endcase
        end
    end

    assign bus.op_ready     = w_op_ready;
    assign bus.sum          = r_sum;
    assign bus.sum_count    = r_sum_count;
    assign bus.sum_overflow = r_sum_ovf;
    assign bus.sum_valid    = r_sum_valid;
endmodule
`default_nettype wire
